uart_tx_buffer: RTL and testbench
=================================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clock  in  1  single clock for all logic.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port push  in  1  one-cycle request to enqueue push_data.
REQ-005 SHALL have port push_data  in  8  byte to enqueue.
REQ-006 SHALL have port clear_overflow  in  1  clears the overflow flag.
REQ-007 SHALL have port full  out  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty  out  1  FIFO holds 0 entries.
REQ-009 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port overflow  out  1  sticky; a push was dropped.
REQ-011 SHALL have port trigger  out  1  one-cycle start pulse to the UART transmitter.
REQ-012 SHALL have port write_data  out  8  byte presented to the UART; valid while trigger is high.
REQ-013 SHALL have port tx_ready  in  1  UART transmitter idle (high) or busy (low).

Function
REQ-014 SHALL buffer bytes in a DEPTH-entry circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-015 SHALL enqueue push_data on a clock edge where push=1 and either full=0 or a pop occurs on the same edge.
REQ-016 SHALL drop push_data when push=1, full=1 and no pop occurs on the same edge, and SHALL set overflow on that edge.
REQ-017 SHALL hold overflow until clear_overflow=1. If clear_overflow and a dropping push occur on the same edge, overflow SHALL end the cycle at 1.
REQ-018 SHALL update count, full and empty on the edge that follows the push or pop. A simultaneous push and pop SHALL leave count unchanged.
REQ-019 SHALL implement the states IDLE, SEND, WAIT_BUSY and WAIT_READY.
REQ-020 IDLE: if empty=0 and tx_ready=1, SHALL pop the head byte into write_data and go to SEND.
REQ-021 SEND: SHALL assert trigger for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: SHALL remain until tx_ready=0, then go to WAIT_READY.
REQ-023 WAIT_READY: SHALL remain until tx_ready=1, then go to IDLE.
REQ-024 SHALL give a minimum latency of 2 cycles from a push into an empty FIFO with tx_ready=1 to trigger=1.
REQ-025 SHALL hold write_data stable from the SEND cycle until the next pop.
REQ-026 SHALL NOT assert trigger in any state other than SEND.

Reset
REQ-027 On reset=1 at a clock edge, SHALL set: state IDLE, pointers 0, count 0, empty 1, full 0, overflow 0, trigger 0, write_data 8'h00.
REQ-028 Reset mid-transfer SHALL abandon the byte in flight and discard all FIFO contents. No trigger SHALL be issued on the edge that follows reset.

Configuration
REQ-029 With macro UART_TX_BUFFER_CRLF_EN defined, popping byte 8'h0A SHALL first send 8'h0D through a full SEND/WAIT_BUSY/WAIT_READY cycle, then send 8'h0A without a further pop.
REQ-030 With UART_TX_BUFFER_CRLF_EN defined, the 8'h0A SHALL occupy the FIFO slot until the 8'h0D completes, then be popped.
REQ-031 Without UART_TX_BUFFER_CRLF_EN, every byte SHALL be sent unmodified, and no CR-pending logic SHALL be synthesised.

Structure
REQ-032 SHALL take the state encoding and the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A from shared package uart_pkg.
REQ-033 SHALL place the FIFO storage and pointers in sub-module byte_fifo, parameterised by DEPTH. byte_fifo SHALL expose push, pop, data, full, empty and count.

Verification
REQ-034 Bench SHALL reset, push 8'h2A with tx_ready=1 -> trigger high for 1 cycle, 2 cycles later, with write_data=8'h2A, then empty=1.
REQ-035 Bench SHALL push 8'h01..8'h03 back-to-back with a UART model whose busy time is 10 cycles -> exactly 3 triggers in order 01,02,03, and no trigger while tx_ready=0.
REQ-036 Bench SHALL hold tx_ready=0 and push DEPTH+1 bytes -> full=1, count=DEPTH, overflow=1, and the last byte is absent from the output. clear_overflow -> overflow=0.
REQ-037 Bench SHALL, at full=1, push and pop on the same edge -> byte accepted, overflow stays 0, count=DEPTH.
REQ-038 Bench SHALL assert reset during WAIT_BUSY with 4 bytes queued -> count=0 and empty=1 on the next cycle, and no trigger after reset.
REQ-039 Bench SHALL, with UART_TX_BUFFER_CRLF_EN defined, push 8'h41,8'h0A -> triggers carry 41,0D,0A. Without the macro -> triggers carry 41,0A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding and the
// ASCII control bytes used by optional CR/LF expansion.
package uart_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SEND       = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY  = 2'd2;
  localparam logic [1:0] ST_WAIT_READY = 2'd3;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO, DEPTH entries (power of two, >= 2). A push into a full
// FIFO is accepted only when a pop happens on the same edge.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  byte_t                    push_data,
  input  logic                     pop,
  output byte_t                    data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign data  = mem[rd_ptr];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer feeding a UART transmitter through a trigger/tx_ready handshake.
// Define UART_TX_BUFFER_CRLF_EN to expand each LF into CR followed by LF.
//
// state         | meaning
// IDLE          | waiting for data and an idle transmitter; pops head byte
// SEND          | one-cycle trigger with write_data valid
// WAIT_BUSY     | waiting for the transmitter to report busy
// WAIT_READY    | waiting for the transmitter to return idle
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     clear_overflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     trigger,
  output logic [7:0]               write_data,
  input  logic                     tx_ready
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pop;
  logic       load;
  byte_t      load_data;
  byte_t      head;
  logic       drop;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .data      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef UART_TX_BUFFER_CRLF_EN
  logic send_cr;
  logic cr_sent;

  // An LF stays at the head of the FIFO while its CR is on the wire.
  always_ff @(posedge clock) begin
    if (reset)        cr_sent <= 1'b0;
    else if (send_cr) cr_sent <= 1'b1;
    else if (pop)     cr_sent <= 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    load_data = head;
`ifdef UART_TX_BUFFER_CRLF_EN
    send_cr   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty && tx_ready) begin
          load      = 1'b1;
          state_nxt = ST_SEND;
`ifdef UART_TX_BUFFER_CRLF_EN
          if (head == ASCII_LF && !cr_sent) begin
            load_data = ASCII_CR;
            send_cr   = 1'b1;
          end else begin
            pop = 1'b1;
          end
`else
          pop = 1'b1;
`endif
        end
      end
      ST_SEND:       state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY:  if (!tx_ready) state_nxt = ST_WAIT_READY;
      ST_WAIT_READY: if (tx_ready) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      write_data <= 8'h00;
    end else begin
      state <= state_nxt;
      if (load) write_data <= load_data;
    end
  end

  // A dropping push wins over a simultaneous clear.
  assign drop = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  assign trigger = (state == ST_SEND);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer with a simple UART busy model.
module tb_uart_tx_buffer;

  localparam int DEPTH   = 16;
  localparam int M_MODEL = 0;
  localparam int M_LOW   = 1;
  localparam int M_HIGH  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        push;
  logic [7:0]  push_data;
  logic        clear_overflow;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        trigger;
  logic [7:0]  write_data;
  logic        tx_ready;

  int          mode;
  int          busy_cnt;
  int          n_bad_trig;
  logic [7:0]  trig_q[$];
  int          n_tests;
  int          n_fail;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .push           (push),
    .push_data      (push_data),
    .clear_overflow (clear_overflow),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .trigger        (trigger),
    .write_data     (write_data),
    .tx_ready       (tx_ready)
  );

  always #5 clock = ~clock;

  assign tx_ready = (mode == M_LOW)  ? 1'b0 :
                    (mode == M_HIGH) ? 1'b1 : (busy_cnt == 0);

  // UART model: busy for 10 cycles after each trigger; logs every trigger.
  always @(posedge clock) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (trigger) begin
      busy_cnt <= 10;
      trig_q.push_back(write_data);
      if (!tx_ready) n_bad_trig <= n_bad_trig + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_trigs(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (trig_q.size() < n && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("trigger_count", trig_q.size(), n);
  endtask

  task automatic push_byte(input logic [7:0] b);
    push      = 1'b1;
    push_data = b;
    @(negedge clock);
    push      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_crlf [3];
    int         n_exp;
    int         snap;

    n_tests = 0; n_fail = 0; n_bad_trig = 0;
    mode = M_MODEL;
    reset = 1'b1; push = 1'b0; push_data = 8'h00; clear_overflow = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_empty",   empty, 1);
    check("rst_full",    full, 0);
    check("rst_count",   count, 0);
    check("rst_ovf",     overflow, 0);
    check("rst_trigger", trigger, 0);
    check("rst_wdata",   write_data, 8'h00);
    reset = 1'b0;
    @(negedge clock);

    // Single byte: trigger two cycles after the push cycle.
    trig_q.delete();
    push = 1'b1; push_data = 8'h2A;
    @(negedge clock);
    push = 1'b0;
    check("lat_trig_c1", trigger, 0);
    @(negedge clock);
    check("lat_trig_c2", trigger, 1);
    check("lat_wdata",   write_data, 8'h2A);
    check("lat_empty",   empty, 1);
    @(negedge clock);
    check("lat_trig_c3", trigger, 0);
    repeat (20) @(negedge clock);
    check("lat_ntrig", trig_q.size(), 1);

    // Three back-to-back bytes against a busy transmitter.
    trig_q.delete();
    for (int i = 0; i < 3; i++) push_byte(8'(i + 1));
    wait_trigs(3, 200);
    for (int i = 0; i < 3; i++)
      if (i < trig_q.size()) check("b2b_byte", trig_q[i], 8'(i + 1));
    repeat (20) @(negedge clock);
    check("b2b_empty", empty, 1);
    check("b2b_no_busy_trig", n_bad_trig, 0);

    // Overflow with transmitter held busy, then push+pop at full.
    trig_q.delete();
    mode = M_LOW;
    for (int i = 0; i <= DEPTH; i++) push_byte(8'h10 + 8'(i));
    check("ovf_full",  full, 1);
    check("ovf_count", count, DEPTH);
    check("ovf_flag",  overflow, 1);
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    check("ovf_clear", overflow, 0);
    push = 1'b1; push_data = 8'h77; mode = M_HIGH;
    @(negedge clock);
    push = 1'b0; mode = M_MODEL;
    check("pp_count", count, DEPTH);
    check("pp_full",  full, 1);
    check("pp_ovf",   overflow, 0);
    wait_trigs(DEPTH + 1, 800);
    for (int i = 0; i <= DEPTH; i++)
      if (i < trig_q.size())
        check("ovf_order", trig_q[i], (i < DEPTH) ? 8'h10 + 8'(i) : 8'h77);
    repeat (20) @(negedge clock);
    check("ovf_drained", empty, 1);

    // Reset while parked in WAIT_BUSY with four bytes queued.
    trig_q.delete();
    mode = M_HIGH;
    for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i));
    check("rip_count_pre", count, 4);
    check("rip_ntrig_pre", trig_q.size(), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rip_count", count, 0);
    check("rip_empty", empty, 1);
    check("rip_trig",  trigger, 0);
    snap = trig_q.size();
    repeat (6) @(negedge clock);
    check("rip_no_trig", trig_q.size(), snap);
    mode = M_MODEL;
    repeat (3) @(negedge clock);

    // LF handling: CR inserted only when the expansion is built in.
    trig_q.delete();
`ifdef UART_TX_BUFFER_CRLF_EN
    exp_crlf[0] = 8'h41; exp_crlf[1] = 8'h0D; exp_crlf[2] = 8'h0A; n_exp = 3;
`else
    exp_crlf[0] = 8'h41; exp_crlf[1] = 8'h0A; exp_crlf[2] = 8'h00; n_exp = 2;
`endif
    push_byte(8'h41);
    push_byte(8'h0A);
    wait_trigs(n_exp, 300);
    for (int i = 0; i < 3; i++)
      if (i < n_exp && i < trig_q.size()) check("lf_byte", trig_q[i], exp_crlf[i]);
    repeat (20) @(negedge clock);
    check("lf_ntrig_final", trig_q.size(), n_exp);
    check("lf_empty", empty, 1);
    check("no_busy_trig", n_bad_trig, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
